aes50_rmii_rx_framer: RTL and testbench

//  Consumes the 3-bit registered RMII receive stream from the aes50_rmii_rxd input gearbox (sclk domain, 50 MHz).

---
 rtl/aes50_rmii_rx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_aes50_rmii_rx_framer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes50_rmii_rx_framer.sv
// rtl/aes50_rmii_rx_framer.sv - RMII receive framer: preamble strip, byte assembly, length/FCS check, counters
// Emits one byte per completed dibit quad, delayed by one byte so the last byte can carry eof status.
module aes50_rmii_rx_framer #(
   parameter int MAX_BYTES = 1536,
   parameter int MIN_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  rmii_q,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_crc_ok,
   output logic        rx_err,
   output logic [10:0] rx_len,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] LEN_MAX     = 11'(MAX_BYTES);
   localparam logic [10:0] LEN_MIN     = 11'(MIN_BYTES);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

   state_t      state, state_nxt;
   logic [2:0]  s1, s1_prev;
   logic        armed;
   logic [1:0]  dibit_cnt;
   logic [7:0]  shift_reg;
   logic [7:0]  pend_data;
   logic        pend_valid, pend_sof;
   logic [10:0] len;
   logic [31:0] crc;
   logic [1:0]  since_emit;
   logic        fl_valid, fl_crc_ok, fl_err;
   logic [10:0] fl_len;

   logic        crs, crs_prev, carrier_end;
   logic [1:0]  dibit;
   logic [7:0]  byte_new;
   logic        byte_done, overflow, end_req, crc_ok_now, end_err, emit_ok;
   logic        eof_direct, eof_flush, eof_fire, eof_crc, eof_err;
   logic [10:0] eof_len;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // The dibit under decision is s1_prev; s1 is the one-cycle lookahead that
   // makes a low crs_dv followed by a high one count as data.
   assign crs         = s1[2];
   assign crs_prev    = s1_prev[2];
   assign dibit       = s1_prev[1:0];
   assign carrier_end = !crs && !crs_prev;
   assign byte_new    = {dibit, shift_reg[7:2]};
   assign byte_done   = (state == DATA) && !carrier_end && (dibit_cnt == 2'd3);
   assign overflow    = byte_done && (len == LEN_MAX);
   assign end_req     = (state == DATA) && carrier_end && pend_valid;
   assign crc_ok_now  = (crc == CRC_RESIDUE);
   assign end_err     = !crc_ok_now || (dibit_cnt != 2'd0) || (len < LEN_MIN);
   assign emit_ok     = (since_emit == 2'd3);

   // The final byte waits until four cycles have passed since the previous one.
   assign eof_direct = end_req && emit_ok;
   assign eof_flush  = !end_req && fl_valid && emit_ok;
   assign eof_fire   = eof_direct || eof_flush;
   assign eof_crc    = eof_direct ? crc_ok_now : fl_crc_ok;
   assign eof_err    = eof_direct ? end_err : fl_err;
   assign eof_len    = eof_direct ? len : fl_len;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (armed && crs_prev && dibit == 2'b01) state_nxt = PRE;
         PRE: begin
            if (carrier_end)           state_nxt = IDLE;
            else if (dibit == 2'b11)   state_nxt = DATA;
            else if (dibit != 2'b01)   state_nxt = DROP;
         end
         DATA: begin
            if (carrier_end)   state_nxt = IDLE;
            else if (overflow) state_nxt = DROP;
         end
         DROP: if (carrier_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1         <= '0;
         s1_prev    <= '0;
         armed      <= 1'b0;
         dibit_cnt  <= '0;
         shift_reg  <= '0;
         pend_data  <= '0;
         pend_valid <= 1'b0;
         pend_sof   <= 1'b0;
         len        <= '0;
         crc        <= CRC_INIT;
         since_emit <= 2'd3;
         fl_valid   <= 1'b0;
         fl_crc_ok  <= 1'b0;
         fl_err     <= 1'b0;
         fl_len     <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         rx_eof     <= 1'b0;
         rx_crc_ok  <= 1'b0;
         rx_err     <= 1'b0;
         rx_len     <= '0;
         frame_cnt  <= '0;
         err_cnt    <= '0;
      end else begin
         s1        <= rmii_q;
         s1_prev   <= s1;
         rx_valid  <= 1'b0;
         rx_sof    <= 1'b0;
         rx_eof    <= 1'b0;
         rx_crc_ok <= 1'b0;
         rx_err    <= 1'b0;
         rx_len    <= '0;
         if (!emit_ok) since_emit <= since_emit + 2'd1;

         if (state == IDLE && state_nxt == PRE) armed <= 1'b0;
         else if (carrier_end)                  armed <= 1'b1;

         if (state == PRE && state_nxt == DATA) begin
            dibit_cnt  <= '0;
            len        <= '0;
            crc        <= CRC_INIT;
            pend_valid <= 1'b0;
         end

         if (state == DATA && !carrier_end) begin
            shift_reg <= byte_new;
            dibit_cnt <= dibit_cnt + 2'd1;
         end

         if (byte_done) begin
            if (pend_valid) begin
               rx_valid   <= 1'b1;
               rx_data    <= pend_data;
               rx_sof     <= pend_sof;
               since_emit <= '0;
            end
            if (overflow) begin
               rx_eof     <= 1'b1;
               rx_err     <= 1'b1;
               rx_crc_ok  <= crc_ok_now;
               rx_len     <= LEN_MAX;
               pend_valid <= 1'b0;
               len        <= LEN_MAX + 11'd1;
               frame_cnt  <= sat_inc(frame_cnt);
               err_cnt    <= sat_inc(err_cnt);
            end else begin
               pend_data  <= byte_new;
               pend_sof   <= (len == 11'd0);
               pend_valid <= 1'b1;
               len        <= len + 11'd1;
               crc        <= crc32_byte(crc, byte_new);
            end
         end

         if (state == DATA && carrier_end) pend_valid <= 1'b0;

         if (eof_fire) begin
            rx_valid   <= 1'b1;
            rx_data    <= pend_data;
            rx_sof     <= pend_sof;
            rx_eof     <= 1'b1;
            rx_crc_ok  <= eof_crc;
            rx_err     <= eof_err;
            rx_len     <= eof_len;
            since_emit <= '0;
            fl_valid   <= 1'b0;
            frame_cnt  <= sat_inc(frame_cnt);
            if (eof_err) err_cnt <= sat_inc(err_cnt);
         end else if (end_req) begin
            fl_valid  <= 1'b1;
            fl_crc_ok <= crc_ok_now;
            fl_err    <= end_err;
            fl_len    <= len;
         end
      end
   end

endmodule

// File: tb/tb_aes50_rmii_rx_framer.sv
// tb/tb_aes50_rmii_rx_framer.sv - scoreboard bench for the RMII receive framer
// Frames are built with their own FCS; expected bytes are queued as they are driven.
module tb_aes50_rmii_rx_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  rmii_q;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
   logic [10:0] rx_len;
   logic [15:0] frame_cnt, err_cnt;

   aes50_rmii_rx_framer dut (
      .clk       (clk),
      .reset     (reset),
      .rmii_q    (rmii_q),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_sof    (rx_sof),
      .rx_eof    (rx_eof),
      .rx_crc_ok (rx_crc_ok),
      .rx_err    (rx_err),
      .rx_len    (rx_len),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [7:0]  data;
      logic        sof, eof, crc_ok, err;
      logic [10:0] len;
      logic [31:0] cyc;
   } obs_t;

   typedef struct packed {
      logic [7:0]  data;
      logic        sof, eof, crc_ok, err, chk_crc;
      logic [10:0] len;
      logic [3:0]  gap;
   } exp_t;

   obs_t        obs [0:4095];
   int          obs_wr = 0;
   int          rd = 0;
   logic [31:0] cyc = '0;
   exp_t        exp_q [$];
   logic [7:0]  frm [$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_frames = '0;
   logic [15:0] exp_errs = '0;
   int          rst_snap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && obs_wr < 4096) begin
         obs[obs_wr] <= '{data: rx_data, sof: rx_sof, eof: rx_eof, crc_ok: rx_crc_ok,
                          err: rx_err, len: rx_len, cyc: cyc};
         obs_wr <= obs_wr + 1;
      end
   end

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r = c;
      for (int b = 0; b < 8; b++) begin
         if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic drive(input logic crs, input logic [1:0] d);
      @(posedge clk);
      #1;
      rmii_q = {crs, d};
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 2'b00);
   endtask

   task automatic send_byte(input logic [7:0] v, input bit tog);
      for (int k = 0; k < 4; k++)
         drive(tog ? logic'(k % 2) : 1'b1, v[2*k +: 2]);
   endtask

   task automatic build_frame(input int n);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
      if (n >= 4) begin
         c = 32'hFFFFFFFF;
         foreach (frm[i]) c = crc_step(c, frm[i]);
         c = ~c;
         for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
      end else begin
         for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
      end
   endtask

   task automatic push_expected(input int n, input logic crc_ok, input logic err,
                                input logic chk, input int len);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{data: frm[i], sof: (i == 0), eof: (i == n - 1), crc_ok: crc_ok,
                           err: err, chk_crc: chk, len: 11'(len), gap: (i == 0) ? 4'd0 : 4'd4});
   endtask

   task automatic send_frame(input int tog_from, input int extra, input int rst_at, input int rst_end);
      idle(4);
      repeat (7) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      for (int b = 0; b < frm.size(); b++) begin
         if (b == rst_at) begin
            reset = 1'b1;
            rst_snap = obs_wr;
         end
         if (b == rst_end) reset = 1'b0;
         send_byte(frm[b], (tog_from >= 0) && (b >= tog_from));
      end
      for (int k = 0; k < extra; k++) drive(1'b1, 2'b10);
      idle(16);
   endtask

   task automatic check_frame(input string name);
      int   n = exp_q.size();
      exp_t e;
      obs_t o;
      for (int t = 0; t < 400 && (obs_wr - rd) < n; t++) @(posedge clk);
      vectors++;
      if (obs_wr - rd != n) begin
         miscompares++;
         $display("FAIL %s byte count: got %0d want %0d", name, obs_wr - rd, n);
      end
      while (exp_q.size() > 0 && rd < obs_wr) begin
         e = exp_q.pop_front();
         o = obs[rd];
         rd++;
         vectors++;
         if ({o.data, o.sof, o.eof} !== {e.data, e.sof, e.eof}) begin
            miscompares++;
            $display("FAIL %s byte %0d: got data=%h sof=%b eof=%b want data=%h sof=%b eof=%b",
                     name, rd, o.data, o.sof, o.eof, e.data, e.sof, e.eof);
         end
         if (e.eof) begin
            vectors++;
            if (o.len !== e.len || o.err !== e.err) begin
               miscompares++;
               $display("FAIL %s eof status: got len=%0d err=%b want len=%0d err=%b",
                        name, o.len, o.err, e.len, e.err);
            end
            if (e.chk_crc) begin
               vectors++;
               if (o.crc_ok !== e.crc_ok) begin
                  miscompares++;
                  $display("FAIL %s crc_ok: got %b want %b", name, o.crc_ok, e.crc_ok);
               end
            end
         end
         if (e.gap != 0) begin
            vectors++;
            if (o.cyc - obs[rd-2].cyc != 32'(e.gap)) begin
               miscompares++;
               $display("FAIL %s spacing: got %0d want %0d", name, o.cyc - obs[rd-2].cyc, e.gap);
            end
         end
      end
      exp_q.delete();
      rd = obs_wr;
      vectors++;
      if (frame_cnt !== exp_frames || err_cnt !== exp_errs) begin
         miscompares++;
         $display("FAIL %s counters: got frames=%0d errs=%0d want frames=%0d errs=%0d",
                  name, frame_cnt, err_cnt, exp_frames, exp_errs);
      end
   endtask

   task automatic good_frame(input string name, input int tog_from);
      build_frame(64);
      push_expected(64, 1'b1, 1'b0, 1'b1, 64);
      exp_frames++;
      send_frame(tog_from, 0, -1, -1);
      check_frame(name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rmii_q = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len, frame_cnt, err_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset outputs: got data=%h valid=%b len=%0d frames=%0d errs=%0d want all 0",
                  rx_data, rx_valid, rx_len, frame_cnt, err_cnt);
      end
      reset = 1'b0;
      idle(4);
   endtask

   task automatic test_good_frame();
      good_frame("good64", -1);
   endtask

   task automatic test_crc_error();
      build_frame(64);
      frm[9] = frm[9] ^ 8'h08;
      push_expected(64, 1'b0, 1'b1, 1'b1, 64);
      exp_frames++;
      exp_errs++;
      send_frame(-1, 0, -1, -1);
      check_frame("crc_bad");
   endtask

   task automatic test_toggle();
      good_frame("toggle", 56);
   endtask

   task automatic test_overflow();
      build_frame(1600);
      push_expected(1536, 1'b0, 1'b1, 1'b0, 1536);
      exp_frames++;
      exp_errs++;
      send_frame(-1, 0, -1, -1);
      check_frame("overflow");
      good_frame("after_overflow", -1);
   endtask

   task automatic test_reset_mid_frame();
      build_frame(64);
      send_frame(-1, 0, 19, 29);
      vectors++;
      if (obs_wr != rst_snap) begin
         miscompares++;
         $display("FAIL reset_mid outputs: got %0d bytes want 0", obs_wr - rst_snap);
      end
      rd = obs_wr;
      exp_frames = '0;
      exp_errs = '0;
      vectors++;
      if (frame_cnt !== exp_frames || err_cnt !== exp_errs) begin
         miscompares++;
         $display("FAIL reset_mid counters: got frames=%0d errs=%0d want 0 0", frame_cnt, err_cnt);
      end
      good_frame("after_reset", -1);
   endtask

   task automatic test_short_align();
      build_frame(60);
      push_expected(60, 1'b1, 1'b1, 1'b1, 60);
      exp_frames++;
      exp_errs++;
      send_frame(-1, 0, -1, -1);
      check_frame("short60");
      build_frame(64);
      push_expected(64, 1'b1, 1'b1, 1'b1, 64);
      exp_frames++;
      exp_errs++;
      send_frame(-1, 2, -1, -1);
      check_frame("align");
   endtask

   task automatic test_boundary();
      build_frame(1);
      push_expected(1, 1'b0, 1'b1, 1'b0, 1);
      exp_frames++;
      exp_errs++;
      send_frame(-1, 0, -1, -1);
      check_frame("one_byte");
      build_frame(0);
      send_frame(-1, 0, -1, -1);
      check_frame("zero_byte");
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_error();
      test_toggle();
      test_overflow();
      test_reset_mid_frame();
      test_short_align();
      test_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
